// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads imem over req/ready and hands words to decode over valid/ready.
// Optional MIPS branch delay slot behaviour is enabled with `define FETCH_DELAY_SLOT_EN.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        imem_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic        instr_valid,
  input  logic        instr_ready,
  input  logic        branch,
  input  logic        branch_cond,
  input  logic        jump,
  output logic [31:0] pc,
  output logic [31:0] link_addr,
  output logic        fetch_err
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_REQ   = 2'd1;
  localparam logic [1:0] S_VALID = 2'd2;

  localparam logic [7:0]  WAIT_LIMIT = 8'(MAX_WAIT);
  localparam logic [31:0] PC_INIT    = {RESET_PC[31:2], 2'b00};

  logic [1:0]  state;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic        err_q;
  logic [7:0]  wait_cnt;

  logic        accept;
  logic        redirect;
  logic [31:0] seq_pc;
  logic [31:0] branch_pc;
  logic [31:0] jump_pc;
  logic [31:0] redirect_pc;

  assign seq_pc      = pc_q + 32'd4;
  assign branch_pc   = seq_pc + {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign jump_pc     = {seq_pc[31:28], instr_q[25:0], 2'b00};
  assign redirect    = jump | (branch & branch_cond);
  assign redirect_pc = jump ? jump_pc : branch_pc;
  assign accept      = (state == S_VALID) && valid_q && instr_ready;

  assign imem_req    = (state == S_REQ);
  assign imem_addr   = pc_q;
  assign pc          = pc_q;
  assign link_addr   = seq_pc;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign instr_valid = valid_q;
  assign fetch_err   = err_q;

  // The wait counter restarts on every entry to S_REQ and saturates; fetch_err is sticky.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      instr_q  <= 32'd0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      wait_cnt <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state    <= S_REQ;
          wait_cnt <= 8'd0;
        end
        S_REQ: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state   <= S_VALID;
          end else if (wait_cnt != WAIT_LIMIT) begin
            wait_cnt <= wait_cnt + 8'd1;
            if (wait_cnt + 8'd1 == WAIT_LIMIT) err_q <= 1'b1;
          end
        end
        S_VALID: begin
          if (accept) begin
            valid_q  <= 1'b0;
            state    <= S_REQ;
            wait_cnt <= 8'd0;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

`ifdef FETCH_DELAY_SLOT_EN
  logic        pending;
  logic [31:0] target_q;

  // A taken redirect first fetches the delay slot; its control inputs are ignored at its accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q     <= PC_INIT;
      pending  <= 1'b0;
      target_q <= PC_INIT;
    end else if (accept) begin
      if (pending) begin
        pc_q    <= target_q;
        pending <= 1'b0;
      end else begin
        pc_q <= seq_pc;
        if (redirect) begin
          target_q <= redirect_pc;
          pending  <= 1'b1;
        end
      end
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q <= PC_INIT;
    end else if (accept) begin
      pc_q <= redirect ? redirect_pc : seq_pc;
    end
  end
`endif

endmodule
